tmds_encoder: RTL and testbench



---
 rtl/tmds_encoder.sv | 107 ++++++++++
 tb/tb_tmds_encoder.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/tmds_encoder.sv
// DVI/TMDS 8b/10b channel encoder: stage 1 builds the transition-minimised q_m word,
// stage 2 applies running-disparity DC balancing or emits control tokens.
module tmds_encoder #(
  parameter int CNT_W = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       de,
  input  logic [1:0] ctrl,
  input  logic [7:0] data,
  output logic [9:0] tmds
);

  localparam logic [9:0] TOKEN_00 = 10'h354;
  localparam logic [9:0] TOKEN_01 = 10'h0AB;
  localparam logic [9:0] TOKEN_10 = 10'h154;
  localparam logic [9:0] TOKEN_11 = 10'h2AB;
  localparam logic signed [CNT_W-1:0] TWO   = CNT_W'(2);
  localparam logic signed [CNT_W-1:0] EIGHT = CNT_W'(8);

  logic [3:0] n1d;
  logic       xnor_mode;
  logic [8:0] q_m_c;
  logic [3:0] n1q_c;

  logic [8:0] q_m_r;
  logic [3:0] n1q_r;
  logic       de_r;
  logic [1:0] ctrl_r;

  logic signed [CNT_W-1:0] cnt;
  logic signed [CNT_W-1:0] cnt_nxt;
  logic signed [CNT_W-1:0] n1q_s;
  logic signed [CNT_W-1:0] diff;
  logic [9:0]              tmds_nxt;
  logic                    cnt_zero;
  logic                    cnt_pos;
  logic                    cnt_neg;
  logic                    q8;

  always_comb begin
    n1d = '0;
    for (int i = 0; i < 8; i++) n1d = n1d + 4'(data[i]);
    xnor_mode = (n1d > 4'd4) || ((n1d == 4'd4) && !data[0]);
    q_m_c    = '0;
    q_m_c[0] = data[0];
    for (int i = 1; i < 8; i++)
      q_m_c[i] = xnor_mode ? ~(q_m_c[i-1] ^ data[i]) : (q_m_c[i-1] ^ data[i]);
    q_m_c[8] = ~xnor_mode;
    n1q_c = '0;
    for (int i = 0; i < 8; i++) n1q_c = n1q_c + 4'(q_m_c[i]);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q_m_r  <= '0;
      n1q_r  <= '0;
      de_r   <= 1'b0;
      ctrl_r <= 2'b00;
    end else begin
      q_m_r  <= q_m_c;
      n1q_r  <= n1q_c;
      de_r   <= de;
      ctrl_r <= ctrl;
    end
  end

  // diff = n1q - n0q = 2*n1q - 8, kept in CNT_W-bit two's complement
  always_comb begin
    n1q_s    = CNT_W'(n1q_r);
    diff     = n1q_s + n1q_s - EIGHT;
    q8       = q_m_r[8];
    cnt_zero = (cnt == '0);
    cnt_neg  = cnt[CNT_W-1];
    cnt_pos  = !cnt_neg && !cnt_zero;
    tmds_nxt = TOKEN_00;
    cnt_nxt  = '0;
    if (!de_r) begin
      unique case (ctrl_r)
        2'b00: tmds_nxt = TOKEN_00;
        2'b01: tmds_nxt = TOKEN_01;
        2'b10: tmds_nxt = TOKEN_10;
        default: tmds_nxt = TOKEN_11;
      endcase
    end else if (cnt_zero || (n1q_r == 4'd4)) begin
      tmds_nxt = {~q8, q8, q8 ? q_m_r[7:0] : ~q_m_r[7:0]};
      cnt_nxt  = q8 ? (cnt + diff) : (cnt - diff);
    end else if ((cnt_pos && (n1q_r > 4'd4)) || (cnt_neg && (n1q_r < 4'd4))) begin
      tmds_nxt = {1'b1, q8, ~q_m_r[7:0]};
      cnt_nxt  = cnt + (q8 ? TWO : '0) - diff;
    end else begin
      tmds_nxt = {1'b0, q8, q_m_r[7:0]};
      cnt_nxt  = cnt - (q8 ? '0 : TWO) + diff;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tmds <= TOKEN_00;
      cnt  <= '0;
    end else begin
      tmds <= tmds_nxt;
      cnt  <= cnt_nxt;
    end
  end

endmodule

// File: tb/tb_tmds_encoder.sv
// Self-checking bench for tmds_encoder: directed vector table, reset corners and
// a randomized soak against a word-disparity reference model.
module tb_tmds_encoder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       de = 1'b0;
  logic [1:0] ctrl = 2'b00;
  logic [7:0] data = 8'h00;
  logic [9:0] tmds;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  tmds_encoder #(.CNT_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .de(de), .ctrl(ctrl), .data(data), .tmds(tmds)
  );

  // Reference model: raw inputs held one cycle, then encoded as a whole word;
  // disparity tracks ones-minus-zeros of every emitted data word.
  bit       m_de1 = 1'b0;
  bit [1:0] m_ctrl1 = 2'b00;
  bit [7:0] m_data1 = 8'h00;
  bit [9:0] m_tmds = 10'h354;
  bit       m_is_data = 1'b0;
  int       m_cnt = 0;

  function automatic bit [9:0] token(bit [1:0] c);
    case (c)
      2'b00: return 10'h354;
      2'b01: return 10'h0AB;
      2'b10: return 10'h154;
      default: return 10'h2AB;
    endcase
  endfunction

  task automatic model_edge();
    bit [8:0] qm;
    bit       use_xnor, inv;
    int       n1, n0;
    if (!rst_n) begin
      m_tmds = 10'h354; m_cnt = 0; m_is_data = 1'b0;
      m_de1 = 1'b0; m_ctrl1 = 2'b00; m_data1 = 8'h00;
      return;
    end
    if (!m_de1) begin
      m_tmds = token(m_ctrl1); m_cnt = 0; m_is_data = 1'b0;
    end else begin
      use_xnor = ($countones(m_data1) > 4) || ($countones(m_data1) == 4 && !m_data1[0]);
      qm[0] = m_data1[0];
      for (int i = 1; i < 8; i++)
        qm[i] = use_xnor ? ~(qm[i-1] ^ m_data1[i]) : (qm[i-1] ^ m_data1[i]);
      qm[8] = !use_xnor;
      n1 = $countones(qm[7:0]);
      n0 = 8 - n1;
      if (m_cnt == 0 || n1 == n0) inv = !qm[8];
      else inv = (m_cnt > 0 && n1 > n0) || (m_cnt < 0 && n0 > n1);
      m_tmds = {inv, qm[8], inv ? ~qm[7:0] : qm[7:0]};
      m_cnt = m_cnt + 2 * $countones(m_tmds) - 10;
      m_is_data = 1'b1;
    end
    m_de1 = de; m_ctrl1 = ctrl; m_data1 = data;
  endtask

  task automatic check(string name, logic [9:0] act, logic [9:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: tmds=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive_step(bit r, bit d, bit [1:0] c, bit [7:0] x);
    rst_n = r; de = d; ctrl = c; data = x;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  typedef struct {
    bit       r;
    bit       d;
    bit [1:0] c;
    bit [7:0] x;
    bit [9:0] e;
  } vec_t;

  vec_t tbl[21];

  initial begin
    int tc, cv;
    // expected column is the output after that row's edge, i.e. the encoding of the previous row
    tbl[0]  = '{1'b0, 1'b1, 2'd0, 8'hAA, 10'h354};
    tbl[1]  = '{1'b0, 1'b1, 2'd0, 8'hAA, 10'h354};
    tbl[2]  = '{1'b1, 1'b0, 2'd0, 8'h00, 10'h354};
    tbl[3]  = '{1'b1, 1'b0, 2'd1, 8'h00, 10'h354};
    tbl[4]  = '{1'b1, 1'b0, 2'd2, 8'h00, 10'h0AB};
    tbl[5]  = '{1'b1, 1'b0, 2'd3, 8'h00, 10'h154};
    tbl[6]  = '{1'b1, 1'b1, 2'd0, 8'h00, 10'h2AB};
    tbl[7]  = '{1'b1, 1'b1, 2'd0, 8'h00, 10'h100};
    tbl[8]  = '{1'b1, 1'b1, 2'd0, 8'h00, 10'h3FF};
    tbl[9]  = '{1'b1, 1'b1, 2'd0, 8'h00, 10'h100};
    tbl[10] = '{1'b1, 1'b1, 2'd0, 8'h00, 10'h3FF};
    tbl[11] = '{1'b1, 1'b1, 2'd0, 8'h00, 10'h100};
    tbl[12] = '{1'b1, 1'b1, 2'd0, 8'h00, 10'h3FF};
    tbl[13] = '{1'b1, 1'b1, 2'd0, 8'h00, 10'h100};
    tbl[14] = '{1'b1, 1'b0, 2'd0, 8'h00, 10'h3FF};
    tbl[15] = '{1'b1, 1'b1, 2'd0, 8'hFF, 10'h354};
    tbl[16] = '{1'b1, 1'b1, 2'd0, 8'h10, 10'h200};
    tbl[17] = '{1'b1, 1'b1, 2'd0, 8'h00, 10'h1F0};
    tbl[18] = '{1'b1, 1'b0, 2'd0, 8'h00, 10'h3FF};
    tbl[19] = '{1'b1, 1'b1, 2'd0, 8'h00, 10'h354};
    tbl[20] = '{1'b1, 1'b1, 2'd0, 8'h00, 10'h100};

    for (int k = 0; k < 21; k++) begin
      drive_step(tbl[k].r, tbl[k].d, tbl[k].c, tbl[k].x);
      check($sformatf("vec%0d", k), tmds, tbl[k].e);
    end

    // reset asserted in the middle of a data burst
    drive_step(1'b1, 1'b1, 2'd0, 8'h5A);
    drive_step(1'b1, 1'b1, 2'd0, 8'hC3);
    drive_step(1'b0, 1'b1, 2'd0, 8'h33);
    check("midrst_hold", tmds, 10'h354);
    drive_step(1'b1, 1'b1, 2'd0, 8'h33);
    check("midrst_rel1", tmds, 10'h354);
    drive_step(1'b1, 1'b1, 2'd0, 8'h33);
    check("midrst_rel2", tmds, m_tmds);

    for (int n = 0; n < 20000; n++) begin
      drive_step(($urandom_range(0, 499) != 0), ($urandom_range(0, 3) != 0),
                 2'($urandom_range(0, 3)), 8'($urandom));
      check("soak", tmds, m_tmds);
      if (m_is_data) begin
        tc = 0;
        for (int i = 0; i < 7; i++) if (tmds[i] != tmds[i+1]) tc++;
        checks++;
        if (tc > 4) begin
          errors++;
          $display("FAIL transitions: tmds=%h has %0d transitions, limit 4", tmds, tc);
        end
      end
      cv = dut.cnt;
      checks++;
      if (cv > 10 || cv < -10) begin
        errors++;
        $display("FAIL cnt_range: cnt=%0d outside [-10,10]", cv);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
